state_dump_unit: RTL and testbench
==================================

// Module: state_dump_unit
// PURPOSE
//  Hardware readback engine that captures processor state after a run: reads all registers, then byte-wide memory.
//  Sits beside Processor; stalls the core, walks register file then memory, streams 32-bit records over valid/ready.
//  Memory bytes are packed little-endian, the inverse of the loader: byte 4k+i -> Dump_Data[8*i +: 8] of word k.
// PARAMETERS
//  NREGS      16      registers dumped, indices 0..NREGS-1
//  MEM_BYTES  4096    bytes dumped, addresses 0..MEM_BYTES-1; multiple of 4
//  MEM_AW     12      memory byte-address width; 2**MEM_AW >= MEM_BYTES
// PORTS
//  Clk        in   1       clock, rising edge
//  Reset      in   1       asynchronous, active-low reset
//  Start      in   1       one-cycle pulse: begin dump; ignored unless FSM is IDLE or DONE
//  Hold       out  1       stall request to the processor; equals Busy
//  Busy       out  1       high from the cycle after Start until the last record is accepted
//  Done       out  1       high in DONE; cleared by the next accepted Start
//  Reg_Addr   out  4       register-file read address
//  Reg_Data   in   32      register read data, combinational from Reg_Addr
//  Mem_Addr   out  MEM_AW  memory byte read address
//  Mem_Data   in   8       memory read data; 1-cycle latency (valid the cycle after Mem_Addr)
//  Dump_Valid out  1       record valid
//  Dump_Ready in   1       consumer accepts the record when Valid && Ready
//  Dump_Tag   out  1       0 = register record, 1 = memory record
//  Dump_Addr  out  MEM_AW  register index (zero-extended) or memory byte address of the word (multiple of 4)
//  Dump_Data  out  32      register value or packed memory word
//  Dump_Last  out  1       high on the final memory record only
// BEHAVIOUR
//  Reset (Reset==0, async): state IDLE.
//   All outputs 0: Hold, Busy, Done, Dump_Valid, Dump_Last, Dump_Tag, Dump_Data, Dump_Addr, Reg_Addr, Mem_Addr.
//   Counters 0. Reset mid-dump aborts at once; no partial record is completed.
//  FSM states: IDLE, REG, MEM_RD, MEM_OUT, DONE.
//  IDLE/DONE, Start=1 -> REG. Reg index=0, Busy=Hold=1 next cycle, Done cleared.
//  REG: Reg_Addr=index. Each cycle with !Dump_Valid, load Reg_Data into Dump_Data and set Dump_Valid.
//   Also Tag=0, Dump_Addr=index.
//   On handshake: if index==NREGS-1 -> MEM_RD with word addr 0, else index+1.
//   Exactly one idle cycle between register records.
//  MEM_RD: issue Mem_Addr = base+0..base+3 on 4 consecutive cycles.
//   Capture Mem_Data one cycle after each address into byte lane i.
//   5 cycles after entering MEM_RD -> MEM_OUT with packed word.
//  MEM_OUT: Dump_Valid=1, Tag=1, Dump_Addr=base, Dump_Last=(base==MEM_BYTES-4).
//   On handshake: if last -> DONE, else base+=4 -> MEM_RD.
//  Handshake rule: once Dump_Valid=1, Data/Addr/Tag/Last hold stable until Valid && Ready.
//   Valid never drops without a handshake.
//  Dump_Ready=0 indefinitely: engine stalls, no counter advances, Mem_Addr holds.
//  Start while busy (REG, MEM_RD, MEM_OUT): ignored, no restart.
//  DONE: Busy=Hold=0, Done=1, Dump_Valid=0. A new Start re-runs from register 0.
//  Total records = NREGS + MEM_BYTES/4 (16+1024=1040 at defaults).
//   Address counters never wrap past MEM_BYTES-1.
// TESTING
//  T1 Reset with Reset=0 mid-dump at record 500 -> all outputs 0 next edge-independent.
//   Then Start -> first record Tag=0 Addr=0.
//  T2 R[1]=32'h0000_00A5, R[15]=32'hDEAD_BEEF, Ready=1 -> record 1 Data=A5, record 15 Data=DEADBEEF.
//   Register records exactly 2 cycles apart.
//  T3 Mem[0..3]=11,22,33,44 -> first Tag=1 record Addr=0 Data=32'h44332211.
//   Mem[0xFFC..0xFFF]=AA,BB,CC,DD -> Addr=0xFFC Data=32'hDDCCBBAA, Last=1, next cycle Done=1.
//  T4 Hold Ready=0 for 20 cycles while a memory record is valid -> Data/Addr unchanged, Mem_Addr frozen.
//   Release Ready -> stream resumes with no record lost or duplicated.
//  T5 Pulse Start during MEM_RD -> ignored, 1040 records total.
//   Start in DONE -> Done drops, second dump identical to first.
//  T6 Random Ready (50%) full dump -> scoreboard vs. memory/register model.
//   1040 records, Last on record 1040 only, Hold high throughout.

Source files
------------

// File: rtl/state_dump_unit.sv
// rtl/state_dump_unit.sv - post-run readback engine streaming register file and memory as 32-bit records
//
// Stalls the processor, reads every register and then all of byte-wide
// memory, and emits one record per register followed by one record per
// 4-byte memory word (little-endian packed) over a valid/ready stream.
//
// Ports:
//   Clk, Reset        clock (rising edge), asynchronous active-low reset
//   Start             one-cycle pulse, accepted only in IDLE or DONE
//   Hold, Busy, Done  processor stall request (= Busy), dump active, dump finished
//   Reg_Addr/Reg_Data register-file read port, combinational data
//   Mem_Addr/Mem_Data memory byte read port, data one cycle after address
//   Dump_*            record stream: Valid/Ready handshake, Tag (0 reg, 1 mem),
//                     Addr (reg index or word byte address), Data, Last

module state_dump_unit #(
    parameter int NREGS     = 16,
    parameter int MEM_BYTES = 4096,
    parameter int MEM_AW    = 12
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              Start,
    output logic              Hold,
    output logic              Busy,
    output logic              Done,
    output logic [3:0]        Reg_Addr,
    input  logic [31:0]       Reg_Data,
    output logic [MEM_AW-1:0] Mem_Addr,
    input  logic [7:0]        Mem_Data,
    output logic              Dump_Valid,
    input  logic              Dump_Ready,
    output logic              Dump_Tag,
    output logic [MEM_AW-1:0] Dump_Addr,
    output logic [31:0]       Dump_Data,
    output logic              Dump_Last
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_REG,
        S_MEM_RD,
        S_MEM_OUT,
        S_DONE
    } state_t;

    localparam logic [3:0]        LAST_REG  = 4'(NREGS - 1);
    localparam logic [MEM_AW-1:0] LAST_BASE = MEM_AW'(MEM_BYTES - 4);
    localparam logic [MEM_AW-1:0] ONE       = MEM_AW'(1);
    localparam logic [MEM_AW-1:0] FOUR      = MEM_AW'(4);

    state_t            state;
    state_t            state_nxt;
    logic [2:0]        rd_cnt;
    logic [MEM_AW-1:0] base;
    logic              hs;

    assign hs   = Dump_Valid && Dump_Ready;
    assign Busy = (state == S_REG) || (state == S_MEM_RD) || (state == S_MEM_OUT);
    assign Hold = Busy;
    assign Done = (state == S_DONE);

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE, S_DONE: if (Start) state_nxt = S_REG;
            S_REG:          if (hs && (Reg_Addr == LAST_REG)) state_nxt = S_MEM_RD;
            S_MEM_RD:       if (rd_cnt == 3'd4) state_nxt = S_MEM_OUT;
            S_MEM_OUT:      if (hs) state_nxt = Dump_Last ? S_DONE : S_MEM_RD;
            default:        state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            Reg_Addr   <= '0;
            Mem_Addr   <= '0;
            base       <= '0;
            rd_cnt     <= '0;
            Dump_Valid <= 1'b0;
            Dump_Tag   <= 1'b0;
            Dump_Addr  <= '0;
            Dump_Data  <= '0;
            Dump_Last  <= 1'b0;
        end else begin
            case (state)
                S_IDLE, S_DONE: begin
                    if (Start) begin
                        Reg_Addr   <= '0;
                        Mem_Addr   <= '0;
                        base       <= '0;
                        rd_cnt     <= '0;
                        Dump_Valid <= 1'b0;
                        Dump_Last  <= 1'b0;
                    end
                end
                S_REG: begin
                    // Load on the cycle after each handshake, which gives one
                    // idle cycle between register records.
                    if (!Dump_Valid) begin
                        Dump_Data  <= Reg_Data;
                        Dump_Addr  <= {{(MEM_AW-4){1'b0}}, Reg_Addr};
                        Dump_Tag   <= 1'b0;
                        Dump_Last  <= 1'b0;
                        Dump_Valid <= 1'b1;
                    end else if (Dump_Ready) begin
                        Dump_Valid <= 1'b0;
                        if (Reg_Addr == LAST_REG) begin
                            base     <= '0;
                            Mem_Addr <= '0;
                            rd_cnt   <= '0;
                        end else begin
                            Reg_Addr <= Reg_Addr + 4'd1;
                        end
                    end
                end
                S_MEM_RD: begin
                    // rd_cnt 0..3 issue addresses base..base+3; data for the
                    // address issued at rd_cnt-1 arrives at rd_cnt 1..4. Shifting
                    // in from the top leaves the first byte in lane 0.
                    if (rd_cnt < 3'd3) Mem_Addr <= Mem_Addr + ONE;
                    if (rd_cnt != 3'd0) Dump_Data <= {Mem_Data, Dump_Data[31:8]};
                    if (rd_cnt == 3'd4) begin
                        rd_cnt     <= '0;
                        Dump_Valid <= 1'b1;
                        Dump_Tag   <= 1'b1;
                        Dump_Addr  <= base;
                        Dump_Last  <= (base == LAST_BASE);
                    end else begin
                        rd_cnt <= rd_cnt + 3'd1;
                    end
                end
                S_MEM_OUT: begin
                    if (Dump_Ready) begin
                        Dump_Valid <= 1'b0;
                        if (Dump_Last) begin
                            Dump_Last <= 1'b0;
                        end else begin
                            base     <= base + FOUR;
                            Mem_Addr <= base + FOUR;
                            rd_cnt   <= '0;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_state_dump_unit.sv
// tb/tb_state_dump_unit.sv - randomized scoreboard bench for state_dump_unit
module tb_state_dump_unit;

    localparam int NREGS     = 16;
    localparam int MEM_BYTES = 4096;
    localparam int MEM_AW    = 12;
    localparam int NREC      = NREGS + MEM_BYTES / 4;

    logic              Clk = 1'b0;
    logic              Reset = 1'b0;
    logic              Start = 1'b0;
    logic              Hold, Busy, Done;
    logic [3:0]        Reg_Addr;
    logic [31:0]       Reg_Data;
    logic [MEM_AW-1:0] Mem_Addr;
    logic [7:0]        Mem_Data = 8'h00;
    logic              Dump_Valid;
    logic              Dump_Ready = 1'b0;
    logic              Dump_Tag;
    logic [MEM_AW-1:0] Dump_Addr;
    logic [31:0]       Dump_Data;
    logic              Dump_Last;

    logic [7:0]  mem  [MEM_BYTES];
    logic [31:0] regs [NREGS];

    int checks = 0;
    int errors = 0;

    state_dump_unit #(.NREGS(NREGS), .MEM_BYTES(MEM_BYTES), .MEM_AW(MEM_AW)) dut (
        .Clk(Clk), .Reset(Reset), .Start(Start), .Hold(Hold), .Busy(Busy), .Done(Done),
        .Reg_Addr(Reg_Addr), .Reg_Data(Reg_Data), .Mem_Addr(Mem_Addr), .Mem_Data(Mem_Data),
        .Dump_Valid(Dump_Valid), .Dump_Ready(Dump_Ready), .Dump_Tag(Dump_Tag),
        .Dump_Addr(Dump_Addr), .Dump_Data(Dump_Data), .Dump_Last(Dump_Last)
    );

    always #5 Clk = ~Clk;

    assign Reg_Data = regs[Reg_Addr];
    always @(posedge Clk) Mem_Data <= mem[Mem_Addr];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Record n of a dump as the spec orders them: registers, then memory words.
    function automatic logic [63:0] exp_rec(input int n);
        int k;
        if (n < NREGS) return {18'b0, 1'b0, 1'b0, 12'(n), regs[n]};
        k = n - NREGS;
        return {18'b0, 1'b1, 1'(k == MEM_BYTES / 4 - 1), 12'(4 * k),
                mem[4*k+3], mem[4*k+2], mem[4*k+1], mem[4*k]};
    endfunction

    function automatic logic [63:0] obs_rec();
        return {18'b0, Dump_Tag, Dump_Last, Dump_Addr, Dump_Data};
    endfunction

    function automatic logic [63:0] all_outs();
        return {3'b0, Hold, Busy, Done, Dump_Valid, Dump_Last, Dump_Tag, Reg_Addr,
                Dump_Data, Dump_Addr[7:0]} | {52'b0, Dump_Addr} | {52'b0, Mem_Addr};
    endfunction

    // mode 0: Ready always 1; 1: Ready random 50%; 2: Ready 1 with a 20-cycle stall
    task automatic run_dump(input int mode, input int abort_at, input int start_cyc);
        int          nrec, cyc, last_hs, stall;
        bit          pending, stall_done;
        logic [63:0] prev;
        logic [MEM_AW-1:0] prev_mem;
        nrec = 0; cyc = 0; last_hs = -10; stall = 0; pending = 0; stall_done = 0;
        prev = '0; prev_mem = '0;
        @(negedge Clk);
        Start = 1'b1;
        @(negedge Clk);
        Start = 1'b0;
        check("start_done_clr", {63'b0, Done}, 64'd0);
        check("start_busy", {62'b0, Busy, Hold}, 64'd3);
        while (nrec < NREC && cyc < 20000) begin
            Start = (cyc == start_cyc);
            check("hold_high", {63'b0, Hold}, 64'd1);
            if (abort_at >= 0 && nrec == abort_at) begin
                Reset = 1'b0;
                #1;
                check("abort_outs_zero", all_outs(), 64'd0);
                Start = 1'b0;
                Dump_Ready = 1'b0;
                @(negedge Clk);
                Reset = 1'b1;
                return;
            end
            if (mode == 2 && !stall_done && stall == 0 && Dump_Valid && Dump_Tag && nrec == 100) begin
                stall = 20;
                stall_done = 1;
            end
            case (mode)
                0:       Dump_Ready = 1'b1;
                1:       Dump_Ready = 1'($urandom_range(0, 1));
                default: Dump_Ready = (stall == 0);
            endcase
            if (pending) begin
                check("valid_held", {63'b0, Dump_Valid}, 64'd1);
                check("rec_stable", obs_rec(), prev);
                check("mem_addr_frozen", {52'b0, Mem_Addr}, {52'b0, prev_mem});
            end
            if (Dump_Valid && Dump_Ready) begin
                check("rec", obs_rec(), exp_rec(nrec));
                if (mode == 0 && nrec > 0 && nrec < NREGS)
                    check("reg_spacing", 64'(cyc - last_hs), 64'd2);
                if (nrec == 1)  check("r1_data", {32'b0, Dump_Data}, 64'h0000_00A5);
                if (nrec == 15) check("r15_data", {32'b0, Dump_Data}, 64'hDEAD_BEEF);
                if (nrec == 16) check("mem0_word", obs_rec(), {18'b0, 2'b10, 12'h000, 32'h4433_2211});
                if (nrec == NREC - 1)
                    check("memlast_word", obs_rec(), {18'b0, 2'b11, 12'hFFC, 32'hDDCC_BBAA});
                nrec++;
                last_hs = cyc;
                pending = 0;
            end else begin
                pending = Dump_Valid;
                prev = obs_rec();
                prev_mem = Mem_Addr;
            end
            @(negedge Clk);
            cyc++;
            if (stall > 0) stall--;
        end
        Start = 1'b0;
        Dump_Ready = 1'b0;
        check("rec_count", 64'(nrec), 64'(NREC));
        check("end_state", {60'b0, Done, Busy, Hold, Dump_Valid}, 64'b1000);
        if (mode == 2) check("stall_seen", {63'b0, stall_done}, 64'd1);
    endtask

    initial begin
        for (int i = 0; i < NREGS; i++) regs[i] = $urandom;
        for (int i = 0; i < MEM_BYTES; i++) mem[i] = 8'($urandom);
        regs[1] = 32'h0000_00A5;
        regs[15] = 32'hDEAD_BEEF;
        mem[0] = 8'h11; mem[1] = 8'h22; mem[2] = 8'h33; mem[3] = 8'h44;
        mem[12'hFFC] = 8'hAA; mem[12'hFFD] = 8'hBB; mem[12'hFFE] = 8'hCC; mem[12'hFFF] = 8'hDD;

        repeat (3) @(negedge Clk);
        check("reset_outs_zero", all_outs(), 64'd0);
        Reset = 1'b1;
        repeat (2) @(negedge Clk);
        check("idle_outs", all_outs(), 64'd0);

        run_dump(0, -1, -1);
        run_dump(2, -1, 100);
        run_dump(1, 500, -1);
        check("post_abort_idle", {61'b0, Busy, Done, Dump_Valid}, 64'd0);
        run_dump(1, -1, -1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
